// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable data RAM with RISC-V load/store size decode,
// valid/ready request port, registered response and optional clear-after-reset.
`timescale 1ns/1ps
module data_memory_lsu #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [XLEN-1:0]       i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [XLEN-1:0]       o_rsp_rdata,
    output logic                  o_rsp_fault,
    output logic                  o_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned LANES = XLEN / 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_busy;
    logic [XLEN-1:0]    r_mem [DEPTH_WORDS];

    // Stage 1: request captured and word read at the accept edge
    logic               r_s1_valid;
    logic               r_s1_we;
    logic               r_s1_fault;
    logic [2:0]         r_s1_f3;
    logic [1:0]         r_s1_lane;
    logic [XLEN-1:0]    r_s1_word;

    // Stage 2: presented response
    logic               r_rsp_valid;
    logic [XLEN-1:0]    r_rsp_rdata;
    logic               r_rsp_fault;

    logic               w_accept;
    logic               w_store;
    logic [IDX_W-1:0]   w_idx;
    logic [1:0]         w_lane;
    logic               w_legal;
    logic               w_misal;
    logic               w_fault;
    logic [LANES-1:0]   w_be;
    logic [XLEN-1:0]    w_wdata;
    logic [XLEN-1:0]    w_shift;
    logic [XLEN-1:0]    w_load_data;
    logic               w_unused_addr;

    assign w_accept      = i_req_valid && r_ready;
    assign w_idx         = i_req_addr[IDX_W+1:2];
    assign w_lane        = i_req_addr[1:0];
    assign w_store       = i_rst_n && w_accept && i_req_we && !w_fault;
    assign w_unused_addr = ^i_req_addr[ADDR_WIDTH-1:IDX_W+2];

    // Size/sign decode, alignment check, byte enables and lane-replicated store data
    always_comb begin
        w_legal = 1'b0;
        w_misal = 1'b0;
        w_be    = '0;
        w_wdata = i_req_wdata;
        case (i_req_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            3'b001: begin
                w_legal = 1'b1;
                w_misal = w_lane[0];
                w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            3'b010: begin
                w_legal = 1'b1;
                w_misal = |w_lane;
                w_be    = 4'b1111;
            end
            3'b100: w_legal = !i_req_we;
            3'b101: begin
                w_legal = !i_req_we;
                w_misal = w_lane[0];
            end
            default: w_legal = 1'b0;
        endcase
        w_fault = !w_legal || w_misal;
    end

    // Storage: clear sweep, byte-lane stores, and synchronous read on accept
    always_ff @(posedge i_clk) begin
        if (i_rst_n && (r_state == ST_CLEAR)) begin
            r_mem[r_cnt] <= '0;
        end else if (w_store) begin
            for (int b = 0; b < LANES; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (w_accept) r_s1_word <= r_mem[w_idx];
    end

    // Select the addressed lane and extend per funct3
    always_comb begin
        w_shift     = r_s1_word >> {r_s1_lane, 3'b000};
        w_load_data = w_shift;
        case (r_s1_f3)
            3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load_data = {24'h0, w_shift[7:0]};
            3'b101:  w_load_data = {16'h0, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // Clear/idle FSM plus the two-stage response pipeline
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            r_cnt       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= CLEAR_ON_RESET;
            r_s1_valid  <= 1'b0;
            r_s1_we     <= 1'b0;
            r_s1_fault  <= 1'b0;
            r_s1_f3     <= 3'b000;
            r_s1_lane   <= 2'b00;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_cnt <= r_cnt + IDX_W'(1);
                    if (r_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase

            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_we    <= i_req_we;
                r_s1_fault <= w_fault;
                r_s1_f3    <= i_req_funct3;
                r_s1_lane  <= w_lane;
            end

            r_rsp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rsp_fault <= r_s1_fault;
                r_rsp_rdata <= (r_s1_fault || r_s1_we) ? '0 : w_load_data;
            end
        end
    end

    assign o_req_ready = r_ready;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_fault = r_rsp_fault;

endmodule
